// File: rtl/cdb_broadcaster_pkg.sv
// Shared constants and the CDB entry type used by the broadcaster, RS and ROB.
package cdb_broadcaster_pkg;

  localparam int unsigned Ways  = 3;   // CDB lanes
  localparam int unsigned NumFu = 6;   // completing functional units
  localparam int unsigned Depth = 8;   // completion buffer entries, power of two, >= Ways
  localparam int unsigned Xlen  = 32;  // result width
  localparam int unsigned Prf   = 64;  // physical registers
  localparam int unsigned Rob   = 16;  // ROB entries

  localparam int unsigned PrfW = $clog2(Prf);
  localparam int unsigned RobW = $clog2(Rob);
  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = $clog2(Depth + 1);

  typedef struct packed {
    logic [Xlen-1:0] data;
    logic [PrfW-1:0] prf_idx;
    logic [RobW-1:0] rob_idx;
  } cdb_entry_t;

endpackage

// File: rtl/cdb_broadcaster_prefix_count.sv
// cdb_prefix_count: fixed-priority (bit 0 highest) admission of a valid vector.
// Ports:
//   valid_i     - requesting units
//   free_i      - slots available this cycle
//   lower_cnt_o - per unit, number of lower-index valid units (its slot offset)
//   accept_o    - unit is admitted (valid and its offset fits in free_i)
//   n_accept_o  - number of admitted units
module cdb_prefix_count #(
  parameter int unsigned N    = 6,
  parameter int unsigned CntW = 4
) (
  input  logic [N-1:0]           valid_i,
  input  logic [CntW-1:0]        free_i,
  output logic [N-1:0][CntW-1:0] lower_cnt_o,
  output logic [N-1:0]           accept_o,
  output logic [CntW-1:0]        n_accept_o
);

  logic [CntW-1:0] acc;

  always_comb begin
    acc         = '0;
    n_accept_o  = '0;
    lower_cnt_o = '0;
    accept_o    = '0;
    for (int i = 0; i < int'(N); i++) begin
      lower_cnt_o[i] = acc;
      accept_o[i]    = valid_i[i] && (acc < free_i);
      if (accept_o[i]) n_accept_o = n_accept_o + 1'b1;
      acc = acc + CntW'(valid_i[i]);
    end
  end

endmodule

// File: rtl/cdb_broadcaster.sv
// cdb_broadcaster: collects FU completions into an in-order circular buffer and
// broadcasts up to Ways of them per cycle on registered CDB lanes, oldest on lane 0.
// Ports:
//   clk_i, rst_ni       - clock, asynchronous active-low reset
//   squash_i            - synchronous flush: empties buffer, kills lanes, drops inputs
//   fu_valid_i/data/prf_idx/rob_idx - per-FU completed results
//   fu_ready_o          - per-FU acceptance this edge (combinational)
//   cdb_valid_o/data/prf_idx/rob_idx - registered broadcast lanes
//   buf_count_o         - registered buffer occupancy
module cdb_broadcaster
  import cdb_broadcaster_pkg::*;
(
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       squash_i,
  input  logic [NumFu-1:0]           fu_valid_i,
  input  logic [NumFu-1:0][Xlen-1:0] fu_data_i,
  input  logic [NumFu-1:0][PrfW-1:0] fu_prf_idx_i,
  input  logic [NumFu-1:0][RobW-1:0] fu_rob_idx_i,
  output logic [NumFu-1:0]           fu_ready_o,
  output logic [Ways-1:0]            cdb_valid_o,
  output logic [Ways-1:0][Xlen-1:0]  cdb_data_o,
  output logic [Ways-1:0][PrfW-1:0]  cdb_prf_idx_o,
  output logic [Ways-1:0][RobW-1:0]  cdb_rob_idx_o,
  output logic [CntW-1:0]            buf_count_o
);

  cdb_entry_t mem_q [Depth];

  logic [PtrW-1:0] head_q, head_d, tail_q, tail_d;
  logic [CntW-1:0] count_q, count_d;
  logic [Ways-1:0] cdb_valid_q, cdb_valid_d;
  cdb_entry_t      cdb_q [Ways];
  cdb_entry_t      cdb_d [Ways];

  logic [CntW-1:0]             n_pop, free, n_accept;
  logic [NumFu-1:0]            req;
  logic [NumFu-1:0]            accept;
  logic [NumFu-1:0][CntW-1:0]  lower_cnt;
  logic [NumFu-1:0][PtrW-1:0]  wr_ptr;

  assign n_pop = (count_q < CntW'(Ways)) ? count_q : CntW'(Ways);
  // Slots popped this cycle are reusable by this cycle's writes.
  assign free  = CntW'(Depth) - count_q + n_pop;
  // Nothing is accepted during squash or while reset is held.
  assign req   = fu_valid_i & {NumFu{~squash_i & rst_ni}};

  cdb_prefix_count #(
    .N    (NumFu),
    .CntW (CntW)
  ) u_prefix (
    .valid_i     (req),
    .free_i      (free),
    .lower_cnt_o (lower_cnt),
    .accept_o    (accept),
    .n_accept_o  (n_accept)
  );

  assign fu_ready_o = accept;

  always_comb begin
    for (int i = 0; i < int'(NumFu); i++) begin
      wr_ptr[i] = tail_q + PtrW'(lower_cnt[i]);
    end
  end

  always_comb begin
    head_d      = head_q + PtrW'(n_pop);
    tail_d      = tail_q + PtrW'(n_accept);
    count_d     = count_q - n_pop + n_accept;
    cdb_valid_d = '0;
    for (int k = 0; k < int'(Ways); k++) begin
      cdb_d[k] = cdb_q[k];  // invalid lanes keep their payload
      if (CntW'(k) < n_pop) begin
        cdb_valid_d[k] = 1'b1;
        cdb_d[k]       = mem_q[head_q + PtrW'(k)];
      end
    end
    if (squash_i) begin
      head_d      = '0;
      tail_d      = '0;
      count_d     = '0;
      cdb_valid_d = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    for (int i = 0; i < int'(NumFu); i++) begin
      if (accept[i]) begin
        mem_q[wr_ptr[i]] <= '{data: fu_data_i[i], prf_idx: fu_prf_idx_i[i],
                              rob_idx: fu_rob_idx_i[i]};
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      cdb_valid_q <= '0;
      for (int k = 0; k < int'(Ways); k++) cdb_q[k] <= '0;
    end else begin
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
      cdb_valid_q <= cdb_valid_d;
      for (int k = 0; k < int'(Ways); k++) cdb_q[k] <= cdb_d[k];
    end
  end

  always_comb begin
    for (int k = 0; k < int'(Ways); k++) begin
      cdb_data_o[k]    = cdb_q[k].data;
      cdb_prf_idx_o[k] = cdb_q[k].prf_idx;
      cdb_rob_idx_o[k] = cdb_q[k].rob_idx;
    end
  end

  assign cdb_valid_o = cdb_valid_q;
  assign buf_count_o = count_q;

endmodule
